// File: rtl/regfile_op_sequencer.sv
// Moore controller stepping one register-level command through the register file, operand registers and ALU.
// Latency 2-6 cycles from handshake to done; cmd_ready is high only in IDLE, so callers stall until then.
module regfile_op_sequencer #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_rd,
    input  logic [IDX_W-1:0] cmd_rn,
    input  logic [IDX_W-1:0] cmd_rm,
    input  logic [1:0]       cmd_shift,
    output logic [IDX_W-1:0] readnum,
    output logic [IDX_W-1:0] writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       shift,
    output logic [1:0]       aluop,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    localparam logic [2:0] OP_MOV_IMM = 3'd0;
    localparam logic [2:0] OP_MOV_REG = 3'd1;
    localparam logic [2:0] OP_ADD     = 3'd2;
    localparam logic [2:0] OP_CMP     = 3'd3;
    localparam logic [2:0] OP_AND     = 3'd4;
    localparam logic [2:0] OP_MVN     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_IMM, S_GET_A, S_GET_B, S_EXEC, S_WR_C, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [IDX_W-1:0] rd_q, rn_q, rm_q;
    logic [1:0]       shift_q;
    logic             accept;

    assign accept = (state_q == S_IDLE) && cmd_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= cmd_op;
                rd_q    <= cmd_rd;
                rn_q    <= cmd_rn;
                rm_q    <= cmd_rm;
                shift_q <= cmd_shift;
            end
        end
    end

    // Routing out of IDLE uses the live opcode; every later state uses the captured one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_MOV_IMM:                 state_d = S_WR_IMM;
                        OP_MOV_REG, OP_MVN:         state_d = S_GET_B;
                        OP_ADD, OP_AND, OP_CMP:     state_d = S_GET_A;
                        default:                    state_d = S_DONE;
                    endcase
                end
            end
            S_WR_IMM: state_d = S_DONE;
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = (op_q == OP_CMP) ? S_DONE : S_WR_C;
            S_WR_C:   state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = 2'b00;
        shift     = 2'b00;
        aluop     = 2'b00;
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        cmd_err   = 1'b0;
        case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_WR_IMM: begin
                writenum = rd_q;
                vsel     = 2'b10;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = shift_q;
                asel  = (op_q == OP_MOV_REG);
                case (op_q)
                    OP_CMP:  aluop = 2'b01;
                    OP_AND:  aluop = 2'b10;
                    OP_MVN:  aluop = 2'b11;
                    default: aluop = 2'b00;
                endcase
                // CMP only updates flags; everything else lands in C for writeback.
                loads = (op_q == OP_CMP);
                loadc = (op_q != OP_CMP);
            end
            S_WR_C: begin
                writenum = rd_q;
                vsel     = 2'b00;
                write    = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                cmd_err = (op_q > OP_MVN);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer: hand-computed per-cycle strobe and index expectations.
module tb_regfile_op_sequencer;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_rd, cmd_rn, cmd_rm;
    logic [1:0] cmd_shift;
    logic [2:0] readnum, writenum;
    logic       write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel, shift, aluop;
    logic       busy, done, cmd_err;

    int n_cmp = 0;
    int n_err = 0;

    regfile_op_sequencer #(.IDX_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_shift(cmd_shift),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {write, loada, loadb, loadc, loads, asel, bsel, done, cmd_err}
    function automatic logic [8:0] strb();
        return {write, loada, loadb, loadc, loads, asel, bsel, done, cmd_err};
    endfunction

    // Called at a negedge; returns at the negedge of cycle T+1 (T = handshake edge).
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [1:0] sh, input bit keep_valid);
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_shift = sh;
        cmd_valid = 1'b1;
        check("issue_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0;
        cmd_op = 3'd0; cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_shift = 2'd0;
        #3;
        check("rst_ready", cmd_ready, 1);
        check("rst_strb",  strb(), 9'b0);
        check("rst_busy",  busy, 0);
        check("rst_idx",   {readnum, writenum, vsel, shift, aluop}, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        next_cycle();

        // 1: reset mid-ADD while in GET_B
        issue(3'd2, 3'd6, 3'd1, 3'd2, 2'd0, 1'b0);
        next_cycle();
        check("t1_getb_strb", strb(), 9'b0_0100_0000);
        #1 reset_n = 1'b0;
        #1;
        check("t1_rst_ready", cmd_ready, 1);
        check("t1_rst_strb",  strb(), 9'b0);
        check("t1_rst_busy",  busy, 0);
        check("t1_rst_idx",   {readnum, writenum}, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("t1_post_strb",  strb(), 9'b0);
            check("t1_post_ready", cmd_ready, 1);
        end
        issue(3'd0, 3'd3, 3'd0, 3'd0, 2'd0, 1'b0);
        check("t1_imm_strb", strb(), 9'b1_0000_0000);
        check("t1_imm_wn",   writenum, 3);
        next_cycle();

        // 2: MOV_IMM rd=5
        next_cycle();
        issue(3'd0, 3'd5, 3'd0, 3'd0, 2'd0, 1'b0);
        check("t2_t1_strb", strb(), 9'b1_0000_0000);
        check("t2_t1_wn",   writenum, 5);
        check("t2_t1_vsel", vsel, 2'b10);
        next_cycle();
        check("t2_t2_strb",  strb(), 9'b0_0000_0010);
        check("t2_t2_ready", cmd_ready, 0);
        next_cycle();
        check("t2_t3_ready", cmd_ready, 1);
        check("t2_t3_busy",  busy, 0);

        // 3: ADD rd=2 rn=0 rm=1 shift=01
        issue(3'd2, 3'd2, 3'd0, 3'd1, 2'd1, 1'b0);
        check("t3_t1_strb", strb(), 9'b0_1000_0000);
        check("t3_t1_rn",   readnum, 0);
        next_cycle();
        check("t3_t2_strb", strb(), 9'b0_0100_0000);
        check("t3_t2_rm",   readnum, 1);
        next_cycle();
        check("t3_t3_strb",  strb(), 9'b0_0010_0000);
        check("t3_t3_alu",   aluop, 2'b00);
        check("t3_t3_shift", shift, 2'b01);
        next_cycle();
        check("t3_t4_strb", strb(), 9'b1_0000_0000);
        check("t3_t4_wn",   writenum, 2);
        check("t3_t4_vsel", vsel, 2'b00);
        next_cycle();
        check("t3_t5_strb", strb(), 9'b0_0000_0010);
        check("t3_t5_busy", busy, 1);
        next_cycle();
        check("t3_t6_ready", cmd_ready, 1);

        // 4: CMP rn=4 rm=4
        issue(3'd3, 3'd1, 3'd4, 3'd4, 2'd0, 1'b0);
        check("t4_t1_strb", strb(), 9'b0_1000_0000);
        check("t4_t1_rn",   readnum, 4);
        next_cycle();
        check("t4_t2_strb", strb(), 9'b0_0100_0000);
        check("t4_t2_rm",   readnum, 4);
        next_cycle();
        check("t4_t3_strb", strb(), 9'b0_0001_0000);
        check("t4_t3_alu",  aluop, 2'b01);
        next_cycle();
        check("t4_t4_strb", strb(), 9'b0_0000_0010);
        next_cycle();
        check("t4_t5_ready", cmd_ready, 1);

        // MOV_REG rd=4 rm=3 shift=11: asel forced, aluop ADD
        issue(3'd1, 3'd4, 3'd7, 3'd3, 2'd3, 1'b0);
        check("mr_t1_strb", strb(), 9'b0_0100_0000);
        check("mr_t1_rm",   readnum, 3);
        next_cycle();
        check("mr_t2_strb",  strb(), 9'b0_0010_1000);
        check("mr_t2_alu",   aluop, 2'b00);
        check("mr_t2_shift", shift, 2'b11);
        next_cycle();
        check("mr_t3_strb", strb(), 9'b1_0000_0000);
        check("mr_t3_wn",   writenum, 4);
        next_cycle();
        check("mr_t4_strb", strb(), 9'b0_0000_0010);
        next_cycle();

        // MVN and AND aluop codes
        issue(3'd5, 3'd0, 3'd0, 3'd6, 2'd2, 1'b0);
        next_cycle();
        check("mvn_exec_strb", strb(), 9'b0_0010_0000);
        check("mvn_exec_alu",  aluop, 2'b11);
        repeat (3) next_cycle();
        issue(3'd4, 3'd7, 3'd2, 3'd5, 2'd0, 1'b0);
        repeat (2) next_cycle();
        check("and_exec_alu", aluop, 2'b10);
        next_cycle();
        check("and_wr_wn", writenum, 7);
        repeat (2) next_cycle();

        // 5: valid held high, fields change mid-command
        issue(3'd2, 3'd6, 3'd1, 3'd2, 2'd2, 1'b1);
        cmd_op = 3'd0; cmd_rd = 3'd7; cmd_rn = 3'd5; cmd_rm = 3'd5; cmd_shift = 2'd1;
        check("t5_t1_rn", readnum, 1);
        next_cycle();
        check("t5_t2_rm", readnum, 2);
        next_cycle();
        check("t5_t3_shift", shift, 2'd2);
        next_cycle();
        check("t5_t4_wn",    writenum, 6);
        check("t5_t4_write", write, 1);
        next_cycle();
        check("t5_t5_done",  done, 1);
        next_cycle();
        check("t5_t6_ready", cmd_ready, 1);
        next_cycle();
        #1 cmd_valid = 1'b0;
        check("t5_t7_strb", strb(), 9'b1_0000_0000);
        check("t5_t7_wn",   writenum, 7);
        repeat (2) next_cycle();

        // 6: illegal op
        issue(3'd7, 3'd2, 3'd3, 3'd4, 2'd1, 1'b0);
        check("t6_t1_strb",  strb(), 9'b0_0000_0011);
        check("t6_t1_ready", cmd_ready, 0);
        next_cycle();
        check("t6_t2_strb",  strb(), 9'b0);
        check("t6_t2_ready", cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
